// File: rtl/interp_stream_pkg.sv
// rtl/interp_stream_pkg.sv - shared types and helpers for the interpreter stream bridge
package interp_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOW,
        HIGH,
        ACK_WAIT
    } ser_state_t;

    localparam int ACK_NONE = 0;
    localparam int ACK_WORD = 1;

    // Minimum of one bit so single-entry counters still elaborate.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with push/pop/full/empty/count
module sync_fifo
    import interp_stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;
    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/interp_stream_bridge.sv
// rtl/interp_stream_bridge.sv - captures COM-qualified read data and serialises it behind a strobe clock
module interp_stream_bridge
    import interp_stream_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int OUT_W    = 8,
    parameter int DEPTH    = 4,
    parameter int CLK_DIV  = 2,
    parameter int ACK_MODE = ACK_NONE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_en,
    input  logic              com,
    input  logic [DATA_W-1:0] data_in,
    input  logic              host_ack,
    output logic              clk_out,
    output logic [OUT_W-1:0]  data_out,
    output logic              busy,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              overflow
);

    localparam int N_CHUNK = DATA_W / OUT_W;
    localparam int CW      = ptr_width(N_CHUNK);
    localparam int DW      = ptr_width(CLK_DIV);
    localparam int PW      = ptr_width(DEPTH);

    ser_state_t        state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [DATA_W-1:0] head;
    logic [CW-1:0]     chunk_idx;
    logic [DW-1:0]     div_cnt;
    logic [PW:0]       fifo_count;
    logic              fifo_full_int;
    logic              push_req;
    logic              pop;
    logic              div_done;
    logic              last_chunk;

    assign push_req   = com && cap_en;
    assign pop        = (state == LOAD);
    assign busy       = (state != IDLE);
    assign fifo_full  = (fifo_count == (PW+1)'(DEPTH));
    assign shift_next = shift_reg >> OUT_W;
    assign div_done   = (div_cnt == DW'(CLK_DIV - 1));
    assign last_chunk = (chunk_idx == CW'(N_CHUNK - 1));

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push_req),
        .push_data (data_in),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full_int),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // clk_out and data_out change only on state transitions, so the host never sees a glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            chunk_idx <= '0;
            div_cnt   <= '0;
            clk_out   <= 1'b0;
            data_out  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push_req && fifo_full_int && !pop) overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (!fifo_empty) state <= LOAD;
                end
                LOAD: begin
                    shift_reg <= head;
                    data_out  <= head[OUT_W-1:0];
                    chunk_idx <= '0;
                    div_cnt   <= '0;
                    clk_out   <= 1'b0;
                    state     <= LOW;
                end
                LOW: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        clk_out <= 1'b1;
                        state   <= HIGH;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        clk_out <= 1'b0;
                        if (!last_chunk) begin
                            shift_reg <= shift_next;
                            data_out  <= shift_next[OUT_W-1:0];
                            chunk_idx <= chunk_idx + 1'b1;
                            state     <= LOW;
                        end else if (ACK_MODE == ACK_WORD) begin
                            state <= ACK_WAIT;
                        end else begin
                            state <= fifo_empty ? IDLE : LOAD;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ACK_WAIT: begin
                    if (host_ack) state <= fifo_empty ? IDLE : LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interp_stream_bridge.sv
// tb/tb_interp_stream_bridge.sv - randomized self-checking bench for both acknowledge modes
module tb_interp_stream_bridge;

    localparam int DATA_W  = 32;
    localparam int OUT_W   = 8;
    localparam int DEPTH   = 4;
    localparam int CLK_DIV = 2;
    localparam int NCH     = DATA_W / OUT_W;
    localparam int WORD_T  = 2 * CLK_DIV * NCH;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              cap_en   = 1'b0;
    logic              com      = 1'b0;
    logic              host_ack = 1'b0;
    logic [DATA_W-1:0] data_in  = '0;
    logic [1:0]        clk_out_v, busy_v, full_v, empty_v, ovf_v;
    logic [OUT_W-1:0]  dout_v [2];
    int                total = 0;
    int                bad = 0;
    bit                ack_noise = 1'b1;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lane 0 streams freely, lane 1 waits for host_ack after every word.
    for (genvar g = 0; g < 2; g++) begin : g_lane
        interp_stream_bridge #(
            .DATA_W(DATA_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .ACK_MODE(g)
        ) dut (
            .clk(clk), .reset(reset), .cap_en(cap_en), .com(com), .data_in(data_in),
            .host_ack(host_ack), .clk_out(clk_out_v[g]), .data_out(dout_v[g]), .busy(busy_v[g]),
            .fifo_full(full_v[g]), .fifo_empty(empty_v[g]), .overflow(ovf_v[g])
        );

        int                mcyc = 0;
        logic [DATA_W-1:0] q[$];
        int                q_edge[$];
        logic [DATA_W-1:0] sent_w[$];
        int                sent_pop[$];
        int                cur_pop = -1;
        int                done_edge = -1000;
        bit                m_ovf = 1'b0;
        bit                m_busy = 1'b0;
        bit                pop_now;
        logic              prev_co = 1'b0;
        int                k = 0;
        int                hi = 0;
        logic [DATA_W-1:0] w;

        // Head word leaves the FIFO one edge after the serializer frees up, or two edges after its push.
        function automatic int head_pop_edge();
            return (q_edge[0] < done_edge) ? done_edge + 1 : q_edge[0] + 2;
        endfunction

        always @(posedge clk) begin
            mcyc++;
            if (!reset) begin
                q.delete(); q_edge.delete(); sent_w.delete(); sent_pop.delete();
                cur_pop = -1; done_edge = -1000; m_ovf = 1'b0; m_busy = 1'b0;
            end else begin
                pop_now = (cur_pop == -1) && (q.size() > 0) && (head_pop_edge() == mcyc);
                if (com && cap_en) begin
                    if (q.size() < DEPTH || pop_now) begin
                        q.push_back(data_in);
                        q_edge.push_back(mcyc);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (pop_now) begin
                    sent_w.push_back(q.pop_front());
                    void'(q_edge.pop_front());
                    sent_pop.push_back(mcyc);
                    cur_pop = mcyc;
                end else if (cur_pop != -1) begin
                    if (g == 0 ? (mcyc == cur_pop + WORD_T) : (mcyc > cur_pop + WORD_T && host_ack)) begin
                        done_edge = mcyc;
                        cur_pop = -1;
                    end
                end
                m_busy = (cur_pop != -1) || (q.size() > 0 && head_pop_edge() == mcyc + 1);
            end
        end

        always @(negedge clk) begin
            chk($sformatf("empty%0d", g), empty_v[g], q.size() == 0);
            chk($sformatf("full%0d", g), full_v[g], q.size() == DEPTH);
            chk($sformatf("ovf%0d", g), ovf_v[g], m_ovf);
            chk($sformatf("busy%0d", g), busy_v[g], m_busy);
            if (!reset) begin
                chk($sformatf("rst_dout%0d", g), dout_v[g], 0);
                chk($sformatf("rst_clk_out%0d", g), clk_out_v[g], 0);
                prev_co = 1'b0; k = 0; hi = 0;
            end else begin
                if (clk_out_v[g] && !prev_co) begin
                    if (sent_w.size() == 0) begin
                        chk($sformatf("unexpected_rise%0d", g), 1, 0);
                    end else begin
                        w = sent_w[0] >> (k * OUT_W);
                        chk($sformatf("chunk%0d", g), dout_v[g], w[OUT_W-1:0]);
                        chk($sformatf("rise_edge%0d", g), mcyc, sent_pop[0] + CLK_DIV + 2 * CLK_DIV * k);
                        k++;
                        if (k == NCH) begin
                            void'(sent_w.pop_front());
                            void'(sent_pop.pop_front());
                            k = 0;
                        end
                    end
                end
                if (clk_out_v[g]) begin
                    hi++;
                end else begin
                    if (prev_co) chk($sformatf("high_len%0d", g), hi, CLK_DIV);
                    hi = 0;
                end
                prev_co = clk_out_v[g];
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        host_ack = ack_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        com = 1'b1; cap_en = 1'b1; data_in = d;
        tick();
        com = 1'b0; cap_en = 1'b0; data_in = $urandom;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy_v != 2'b00 || empty_v != 2'b11) && n < 3000) begin
            tick();
            n++;
        end
        chk(tag, n < 3000, 1);
        tick();
        tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("reset_empty", empty_v, 2'b11);
        chk("reset_full", full_v, 2'b00);
        chk("reset_busy", busy_v, 2'b00);
        reset = 1'b1;
        tick();

        // single word, LSB chunk first, 17-cycle word time
        push(32'hDDCCBBAA);
        tick(); tick();
        chk("t1_first_chunk", dout_v[0], 8'hAA);
        chk("t1_first_low", clk_out_v[0], 0);
        repeat (15) tick();
        chk("t1_busy_last", busy_v[0], 1);
        tick();
        chk("t1_idle", busy_v[0], 0);
        wait_idle("t1_timeout");

        // cap_en without com never captures
        cap_en = 1'b1; com = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_empty", empty_v, 2'b11);
            chk("t2_no_strobe", clk_out_v, 2'b00);
        end
        cap_en = 1'b0;

        // back-to-back burst overflows on the sixth word
        for (int i = 1; i <= 6; i++) push(DATA_W'(i));
        chk("t3_ovf", ovf_v, 2'b11);
        wait_idle("t3_timeout");
        chk("t3_ovf_sticky", ovf_v, 2'b11);

        // word acknowledge holds the second word back
        pulse_reset();
        ack_noise = 1'b0;
        host_ack = 1'b0;
        push(32'h11111111);
        push(32'h22222222);
        repeat (17) tick();
        for (int i = 0; i < 10; i++) begin
            chk("t4_ackwait_low", clk_out_v[1], 0);
            chk("t4_ackwait_busy", busy_v[1], 1);
            tick();
        end
        host_ack = 1'b1;
        tick();
        tick();
        chk("t4_second_word", dout_v[1], 8'h22);
        ack_noise = 1'b1;
        wait_idle("t4_timeout");

        // push onto a full FIFO in the LOAD cycle is accepted
        pulse_reset();
        push($urandom);
        tick(); tick();
        for (int i = 0; i < 4; i++) push($urandom);
        repeat (12) tick();
        push(32'h00000099);
        chk("t5_no_ovf", ovf_v[0], 0);
        chk("t5_full", full_v[0], 1);
        wait_idle("t5_timeout");

        // asynchronous reset in the middle of the second chunk
        pulse_reset();
        push(32'hA5C35A3C);
        repeat (7) tick();
        #2 reset = 1'b0;
        #1;
        chk("t6_clk_out", clk_out_v, 2'b00);
        chk("t6_busy", busy_v, 2'b00);
        chk("t6_empty", empty_v, 2'b11);
        chk("t6_ovf", ovf_v, 2'b00);
        chk("t6_dout0", dout_v[0], 0);
        chk("t6_dout1", dout_v[1], 0);
        tick();
        reset = 1'b1;
        tick();
        push(32'h12345678);
        tick(); tick();
        chk("t6_restart_chunk", dout_v[0], 8'h78);
        wait_idle("t6_timeout");

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            com = ($urandom_range(0, 2) == 0);
            cap_en = ($urandom_range(0, 3) != 0);
            data_in = $urandom;
            tick();
        end
        com = 1'b0; cap_en = 1'b0;
        wait_idle("rand_timeout");
        chk("drain0", g_lane[0].sent_w.size(), 0);
        chk("drain1", g_lane[1].sent_w.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interp_stream_bridge.md
Name: interp_stream_bridge

Overview:
Parametrised successor to the interpreter communication link. It captures processor read-data words whenever the COM flag qualifies a memory-to-register access, and buffers them in a DEPTH-entry FIFO. Each word is serialised into OUT_W-bit chunks behind a generated strobe clock (clk_out) for the external interpreter. An optional per-word acknowledge handshake from the host is supported. It sits beside the data memory in the top level, fed by the CPU's MemtoRegM/COMFlag and the RAM's read data.

Parameters:
DATA_W, 32, width of captured word; must be an integer multiple of OUT_W
OUT_W, 8, width of data_out chunk
DEPTH, 4, FIFO entries; power of two, >= 2
CLK_DIV, 2, clk cycles per clk_out half-period; >= 1
ACK_MODE, 0, 0 = free-running stream; 1 = wait for host_ack after each word

Ports:
clk  in  1  system clock (processor clock domain)
reset  in  1  asynchronous, active-low reset
cap_en  in  1  MemtoReg qualifier from pipeline
com  in  1  COM flag from processor
data_in  in  DATA_W  read data from data memory
host_ack  in  1  word acknowledge from interpreter (used only when ACK_MODE=1)
clk_out  out  1  strobe to interpreter; host samples data_out on its rising edge
data_out  out  OUT_W  current chunk
busy  out  1  serializer not in IDLE
fifo_full  out  1  FIFO holds DEPTH words
fifo_empty  out  1  FIFO holds 0 words
overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset (reset=0, asynchronous): FIFO pointers/count = 0, FSM = IDLE, clk_out=0, data_out=0, busy=0, overflow=0, fifo_empty=1, fifo_full=0. Asserting reset mid-word aborts the word with no completion.
- Push: on a clk rising edge with com=1 and cap_en=1, data_in is written to the FIFO. If the FIFO is full and no pop occurs in the same cycle, the push is dropped and overflow is set. overflow stays at 1 until reset.
- Simultaneous push and pop: both take effect and the count is unchanged. This applies even when the FIFO is full (the push is accepted) and when it holds one word.
- Pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.
- FSM states: IDLE, LOAD, LOW, HIGH, ACK_WAIT.
  - IDLE -> LOAD when fifo_empty=0.
  - LOAD: pop the head word into the shift register; chunk index = 0. Next state is LOW.
  - LOW: data_out = shift[OUT_W-1:0]; clk_out=0; hold for CLK_DIV cycles, then go to HIGH.
  - HIGH: clk_out=1; hold for CLK_DIV cycles.
    - If more chunks remain: shift right by OUT_W, increment the index, go to LOW.
    - If it is the last chunk and ACK_MODE=0: go to LOAD if the FIFO is non-empty, else IDLE.
    - If it is the last chunk and ACK_MODE=1: go to ACK_WAIT.
  - ACK_WAIT: clk_out=0; data_out holds the last chunk. On host_ack=1, go to LOAD if the FIFO is non-empty, else IDLE.
- Chunk order is LSB chunk first. There are DATA_W/OUT_W chunks per word.
- Latency: a push at edge N gives fifo_empty=0 after N. LOAD runs in cycle N+1. The first chunk appears on data_out with clk_out=0 in cycle N+2. The first clk_out rise is at N+2+CLK_DIV.
- Word time (ACK_MODE=0) is 1 + 2·CLK_DIV·(DATA_W/OUT_W) cycles, including LOAD.
- data_out holds its last value in IDLE.
- busy=1 in every state except IDLE.
- A com or cap_en drop mid-word does not affect an in-progress transfer.
- host_ack in any state other than ACK_WAIT is ignored.
- clk_out is a registered output, glitch-free.

Decomposition:
- Package interp_stream_pkg holds:
  - a state enum typedef (IDLE, LOAD, LOW, HIGH, ACK_WAIT);
  - a function clog2-based pointer width helper;
  - the ACK_MODE constants ACK_NONE=0 and ACK_WORD=1.
- One sub-module, sync_fifo, which is parametrised on width and depth, with push/pop/full/empty/count.
- The serializer FSM, divider counter and chunk counter live in the top of the block.

Test Plan:
1. Defaults, ACK_MODE=0. Push 0xDDCCBBAA once.
   - data_out must show 0xAA, 0xBB, 0xCC, 0xDD, each stable across a clk_out rise.
   - 4 clk_out rising edges, each high for 2 cycles.
   - busy returns to 0 after 17 cycles from LOAD.
2. Push only with com=1 and cap_en=1. Drive cap_en=1 with com=0 for 3 cycles.
   - fifo_empty must stay 1 and no clk_out activity.
3. Overflow. Push 6 consecutive words 0x1..0x6 back to back.
   - Word 1 is popped at the LOAD cycle, so words 2–5 fill the FIFO.
   - Word 6 arrives on a full FIFO with no pop that cycle and is dropped; overflow=1 and stays set.
   - Output order is 0x1, 0x2, 0x3, 0x4, 0x5.
4. ACK_MODE=1. Push 0x11111111 and 0x22222222.
   - After the 4th chunk, the FSM sits in ACK_WAIT with clk_out=0 for 10 cycles.
   - A one-cycle host_ack releases the FSM; the second word starts with 0x22 after LOAD.
5. Full with simultaneous push/pop. With the FIFO full, push 0x99 in the LOAD cycle.
   - The push is accepted, overflow stays 0, and 0x99 is transmitted last.
6. Mid-word reset. Assert reset during the second chunk.
   - All outputs go to reset values immediately, without waiting for a clk edge.
   - After release, a new push of 0x12345678 transmits 0x78 first.
